// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator on the pixel clock.
// Walks h/v counters and registers sync, blanking, coordinates and strobes.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COUNT_W   = 10
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_VISIBLE);
    localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [COUNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [COUNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic [COUNT_W-1:0] pixel_x_q, pixel_x_d;
    logic [COUNT_W-1:0] pixel_y_q, pixel_y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    // Advance the raster counters and the completed-frame count.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        if (enable) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + COUNT_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + COUNT_W'(1);
                if (v_wrap) begin
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
        end
    end

    // Decode the pre-edge position into the next output values.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            hsync_d = (h_cnt_q >= HS_FIRST && h_cnt_q <= HS_LAST)
                      ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = (v_cnt_q >= VS_FIRST && v_cnt_q <= VS_LAST)
                      ? VSYNC_POL : ~VSYNC_POL;
            video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // State and output registers; reset parks the raster at the origin.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for the raster generator on a shrunken raster.
// Table vectors, hand sequences and random enable/reset against a model.
module tb_vga_timing_gen;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 5;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] frame_count;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .COUNT_W(10)
    ) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        int   kk;
        out_t exp;
    } vec_t;

    out_t act;
    out_t cur;
    int   k = 0;
    int   errors = 0;
    int   checks = 0;

    assign act = {pixel_x, pixel_y, hsync, vsync, video_on,
                  line_start, frame_start, frame_count};

    function automatic out_t mk(int x, int y, bit hs, bit vs, bit von,
                                bit ls, bit fs, int fc);
        out_t o;
        o.x = 10'(x);
        o.y = 10'(y);
        o.hs = hs;
        o.vs = vs;
        o.von = von;
        o.ls = ls;
        o.fs = fs;
        o.fc = 8'(fc);
        return o;
    endfunction

    // Expected outputs after k enabled edges since reset release.
    function automatic out_t model_at(int kk);
        int h;
        int v;
        if (kk == 0) return mk(0, 0, ~HP, ~VP, 0, 0, 0, 0);
        h = (kk - 1) % HT;
        v = ((kk - 1) / HT) % VT;
        return mk(h, v,
                  (h >= HV + HF && h < HV + HF + HS) ? HP : ~HP,
                  (v >= VV + VF && v < VV + VF + VS) ? VP : ~VP,
                  (h < HV) && (v < VV),
                  h == 0, h == 0 && v == 0,
                  (kk / FR) % 256);
    endfunction

    task automatic cmp(input string nm, input out_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s k=%0d got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                     nm, k, act.x, act.y, act.hs, act.vs, act.von, act.ls,
                     act.fs, act.fc, want.x, want.y, want.hs, want.vs,
                     want.von, want.ls, want.fs, want.fc);
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s k=%0d got %0d want %0d", nm, k, got, want);
        end
    endtask

    // One clock with the given enable; returns at the following negedge.
    task automatic tick(input logic en);
        enable = en;
        @(posedge clk_in);
        if (en) begin
            k++;
            cur = model_at(k);
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
        end
        @(negedge clk_in);
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            tick(1'b1);
            cmp("model", cur);
        end
    endtask

    // Asynchronous reset asserted off the clock edge, released on a negedge.
    task automatic do_reset();
        #1 reset = 1'b1;
        k = 0;
        cur = model_at(0);
        #1 cmp("reset_async", mk(0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk_in);
        cmp("reset_hold", cur);
        reset = 1'b0;
    endtask

    vec_t tbl[19];
    int   nls;

    initial begin
        tbl[0]  = '{1,   mk(0, 0, 1, 0, 1, 1, 1, 0)};
        tbl[1]  = '{8,   mk(7, 0, 1, 0, 1, 0, 0, 0)};
        tbl[2]  = '{9,   mk(8, 0, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{11,  mk(10, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{13,  mk(12, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{14,  mk(13, 0, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{15,  mk(14, 0, 1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{16,  mk(0, 1, 1, 0, 1, 1, 0, 0)};
        tbl[8]  = '{68,  mk(7, 4, 1, 0, 1, 0, 0, 0)};
        tbl[9]  = '{72,  mk(11, 4, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{75,  mk(14, 4, 1, 0, 0, 0, 0, 0)};
        tbl[11] = '{76,  mk(0, 5, 1, 0, 0, 1, 0, 0)};
        tbl[12] = '{91,  mk(0, 6, 1, 1, 0, 1, 0, 0)};
        tbl[13] = '{106, mk(0, 7, 1, 1, 0, 1, 0, 0)};
        tbl[14] = '{120, mk(14, 7, 1, 1, 0, 0, 0, 0)};
        tbl[15] = '{121, mk(0, 8, 1, 0, 0, 1, 0, 0)};
        tbl[16] = '{134, mk(13, 8, 1, 0, 0, 0, 0, 0)};
        tbl[17] = '{135, mk(14, 8, 1, 0, 0, 0, 0, 1)};
        tbl[18] = '{136, mk(0, 0, 1, 0, 1, 1, 1, 1)};

        @(negedge clk_in);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            run_to(tbl[i].kk);
            cmp($sformatf("vec%0d", i), tbl[i].exp);
        end

        do_reset();
        run_to(5);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            cmp("hold_x4", mk(4, 0, 1, 0, 1, 0, 0, 0));
        end
        tick(1'b1);
        cmp_int("resume_x5", int'(pixel_x), 5);
        tick(1'b1);
        cmp_int("resume_x6", int'(pixel_x), 6);

        run_to(14);
        nls = 0;
        for (int i = 0; i < 10; i++) begin
            tick((i < 2 || i > 6) ? 1'b1 : 1'b0);
            cmp("hold_h0", cur);
            if (line_start) nls++;
        end
        cmp_int("hold_h0_ls_once", nls, 1);

        run_to(FR + 53);
        cmp_int("pre_reset_fc", int'(frame_count), 1);
        do_reset();
        tick(1'b1);
        cmp("post_reset_e1", mk(0, 0, 1, 0, 1, 1, 1, 0));

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            tick($urandom_range(0, 3) != 0);
            cmp("random", cur);
        end

        do_reset();
        run_to(255 * FR);
        cmp_int("fc_255", int'(frame_count), 255);
        run_to(256 * FR);
        cmp_int("fc_wrap0", int'(frame_count), 0);
        tick(1'b1);
        cmp("wrap_fs", mk(0, 0, 1, 0, 1, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
